sram_cluster_input: RTL and testbench
=====================================

SRAM_CLUSTER_INPUT -- requirements
Module: sram_cluster_input

Interface
REQ-001 Parameter: ROW_W, 9, row address width of each 8-bit SRAM bank.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  1  fabric request valid.
REQ-006 req_ready  out  1  block accepts request; transfer on req_valid & req_ready at rising edge.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_addr  in  ROW_W+2  byte address; [1:0] lane offset, [ROW_W+1:2] bank row.
REQ-010 d_fabric_in  in  32  write data, right-justified for byte/halfword.
REQ-011 sram_addr  out  ROW_W  row address shared by banks A-D.
REQ-012 csb_A, csb_B, csb_C, csb_D  out  1 each  bank chip select, active-low.
REQ-013 web  out  1  shared bank write enable, active-low.
REQ-014 din_A, din_B, din_C, din_D  out  8 each  bank write data.
REQ-015 csb_out_A, csb_out_B, csb_out_C, csb_out_D  out  1 each  active-high lane-valid flags to the cluster output mux.
REQ-016 rd_valid  out  1  one-cycle pulse: read data valid on cluster output this cycle.
REQ-017 wr_done  out  1  one-cycle pulse: write committed.
REQ-018 err  out  1  one-cycle pulse: request rejected, no bank access.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, RESP, ERR; req_ready SHALL be 1 only in IDLE with rst low.
REQ-020 Lane order: offset 0->A, 1->B, 2->C, 3->D; word packing {A,B,C,D}, A = bits 31:24.
REQ-021 Legal requests: byte any offset; halfword offset 0 (A,B) or 2 (C,D); word offset 0 (A-D).
REQ-022 Illegal request (req_size 11, odd halfword offset, nonzero word offset) SHALL go IDLE->ERR; err=1 in ERR; ERR->IDLE next cycle; no csb asserted.
REQ-023 Legal accepted request SHALL go IDLE->ACCESS, latching we, lanes, row, data into registers.
REQ-024 ACCESS (one cycle): selected lanes' csb_X=0, unselected =1; web=~we; sram_addr=row; outputs registered, glitch-free.
REQ-025 Write data mapping: byte -> d[7:0] to selected lane; halfword -> d[15:8] upper lane, d[7:0] lower lane; word -> A=d[31:24] .. D=d[7:0]; unselected din = 0.
REQ-026 ACCESS->RESP unconditionally; in RESP all csb=1, web=1.
REQ-027 RESP on read: csb_out_X=1 for selected lanes, rd_valid=1; on write: wr_done=1, csb_out_X=0; RESP->IDLE.
REQ-028 Lane flag patterns: byte 1000/0100/0010/0001 (A..D), halfword 1100/0011, word 1111.
REQ-029 Latency: accept at edge N, ACCESS cycle N+1, RESP cycle N+2, req_ready high cycle N+3; one request per 3 cycles maximum.
REQ-030 Inputs outside IDLE SHALL be ignored; req_valid held high is accepted again only in IDLE.
REQ-031 err, rd_valid, wr_done SHALL be mutually exclusive and never high for more than one consecutive cycle per request.

Reset
REQ-032 rst=1 SHALL force, at next edge: state IDLE, csb_A-D=1, web=1, sram_addr=0, din_A-D=0, csb_out_A-D=0, rd_valid=0, wr_done=0, err=0; req_ready=0 while rst=1.
REQ-033 rst asserted in ACCESS or RESP SHALL abort the transaction: no rd_valid/wr_done pulse follows; req_ready=1 first cycle after rst deasserts.

Verification
REQ-034 Word write addr 0x010, data 0xDEADBEEF -> ACCESS: csb all 0, web=0, sram_addr=0x004, din A..D = DE,AD,BE,EF; RESP wr_done=1.
REQ-035 Byte read addr 0x013 -> ACCESS csb_D=0 only, web=1; RESP csb_out=0001, rd_valid=1; cluster output = {24'b0, D}.
REQ-036 Halfword write addr 0x002 data 0x00001234 -> csb_C=csb_D=0, din_C=0x12, din_D=0x34, din_A=din_B=0.
REQ-037 Halfword read addr 0x001 and size 11 -> err pulse one cycle each, csb stays 1111, ready back after 2 cycles.
REQ-038 req_valid held high with 3 back-to-back reads -> accepts every 3rd cycle, exactly 3 rd_valid pulses.
REQ-039 rst asserted during ACCESS of a read -> next cycle all outputs at reset values, no rd_valid.

Source files
------------

// File: rtl/sram_cluster_input.sv
// Fabric-side front end for a cluster of four 8-bit SRAM banks (A..D).
// Accepts one byte/halfword/word request at a time, drives the banks for a
// single ACCESS cycle, then reports completion in RESP (or rejects in ERR).
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE, not in reset)
//   req_we, req_size     1=write; size 00 byte, 01 halfword, 10 word, 11 illegal
//   req_addr             byte address: [1:0] lane offset, [ROW_W+1:2] bank row
//   d_fabric_in          write data, right-justified for byte/halfword
//   sram_addr            row address shared by all banks
//   csb_A..D, web        active-low bank selects and shared write enable
//   din_A..D             per-bank write data
//   csb_out_A..D         active-high lane-valid flags to the cluster output mux
//   rd_valid, wr_done, err  single-cycle completion/reject pulses
module sram_cluster_input #(
  parameter int unsigned ROW_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic [ROW_W+1:0] req_addr,
  input  logic [31:0]      d_fabric_in,
  output logic [ROW_W-1:0] sram_addr,
  output logic             csb_A,
  output logic             csb_B,
  output logic             csb_C,
  output logic             csb_D,
  output logic             web,
  output logic [7:0]       din_A,
  output logic [7:0]       din_B,
  output logic [7:0]       din_C,
  output logic [7:0]       din_D,
  output logic             csb_out_A,
  output logic             csb_out_B,
  output logic             csb_out_C,
  output logic             csb_out_D,
  output logic             rd_valid,
  output logic             wr_done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t           state_q, state_d;
  logic [3:0]       lanes_q, lanes_d;   // {A,B,C,D}
  logic             we_q, we_d;
  logic [3:0]       csb_q, csb_d;
  logic             web_q, web_d;
  logic [ROW_W-1:0] addr_q, addr_d;
  logic [31:0]      din_q, din_d;       // {A,B,C,D}
  logic [3:0]       cso_q, cso_d;
  logic             rdv_q, rdv_d;
  logic             wrd_q, wrd_d;
  logic             err_q, err_d;

  logic             req_legal;
  logic [3:0]       req_lanes;
  logic [31:0]      req_din;

  // Decode size/offset into lane mask and lane-aligned write data.
  always_comb begin
    req_legal = 1'b0;
    req_lanes = 4'b0000;
    req_din   = 32'h0;
    case (req_size)
      2'b00: begin
        req_legal = 1'b1;
        case (req_addr[1:0])
          2'd0:    begin req_lanes = 4'b1000; req_din = {d_fabric_in[7:0], 24'h0}; end
          2'd1:    begin req_lanes = 4'b0100; req_din = {8'h0, d_fabric_in[7:0], 16'h0}; end
          2'd2:    begin req_lanes = 4'b0010; req_din = {16'h0, d_fabric_in[7:0], 8'h0}; end
          default: begin req_lanes = 4'b0001; req_din = {24'h0, d_fabric_in[7:0]}; end
        endcase
      end
      2'b01: begin
        if (req_addr[1:0] == 2'd0) begin
          req_legal = 1'b1;
          req_lanes = 4'b1100;
          req_din   = {d_fabric_in[15:0], 16'h0};
        end else if (req_addr[1:0] == 2'd2) begin
          req_legal = 1'b1;
          req_lanes = 4'b0011;
          req_din   = {16'h0, d_fabric_in[15:0]};
        end
      end
      2'b10: begin
        if (req_addr[1:0] == 2'd0) begin
          req_legal = 1'b1;
          req_lanes = 4'b1111;
          req_din   = d_fabric_in;
        end
      end
      default: ;
    endcase
  end

  // Next state and next registered outputs; outputs are idle unless set below.
  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    we_d    = we_q;
    csb_d   = 4'b1111;
    web_d   = 1'b1;
    addr_d  = addr_q;
    din_d   = 32'h0;
    cso_d   = 4'b0000;
    rdv_d   = 1'b0;
    wrd_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_legal) begin
            state_d = ACCESS;
            lanes_d = req_lanes;
            we_d    = req_we;
            csb_d   = ~req_lanes;
            web_d   = ~req_we;
            addr_d  = req_addr[ROW_W+1:2];
            din_d   = req_din;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        state_d = RESP;
        cso_d   = we_q ? 4'b0000 : lanes_q;
        rdv_d   = ~we_q;
        wrd_d   = we_q;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lanes_q <= 4'b0000;
      we_q    <= 1'b0;
      csb_q   <= 4'b1111;
      web_q   <= 1'b1;
      addr_q  <= '0;
      din_q   <= 32'h0;
      cso_q   <= 4'b0000;
      rdv_q   <= 1'b0;
      wrd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      we_q    <= we_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      cso_q   <= cso_d;
      rdv_q   <= rdv_d;
      wrd_q   <= wrd_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE) && !rst;

  assign sram_addr = addr_q;
  assign {csb_A, csb_B, csb_C, csb_D} = csb_q;
  assign web = web_q;
  assign {din_A, din_B, din_C, din_D} = din_q;
  assign {csb_out_A, csb_out_B, csb_out_C, csb_out_D} = cso_q;
  assign rd_valid = rdv_q;
  assign wr_done  = wrd_q;
  assign err      = err_q;

endmodule

// File: tb/tb_sram_cluster_input.sv
// Directed bench for sram_cluster_input with hand-computed expectations.
module tb_sram_cluster_input;

  localparam int unsigned ROW_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [1:0]       req_size;
  logic [ROW_W+1:0] req_addr;
  logic [31:0]      d_fabric_in;
  logic [ROW_W-1:0] sram_addr;
  logic             csb_A, csb_B, csb_C, csb_D, web;
  logic [7:0]       din_A, din_B, din_C, din_D;
  logic             csb_out_A, csb_out_B, csb_out_C, csb_out_D;
  logic             rd_valid, wr_done, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sram_cluster_input #(.ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .d_fabric_in(d_fabric_in),
    .sram_addr(sram_addr),
    .csb_A(csb_A), .csb_B(csb_B), .csb_C(csb_C), .csb_D(csb_D), .web(web),
    .din_A(din_A), .din_B(din_B), .din_C(din_C), .din_D(din_D),
    .csb_out_A(csb_out_A), .csb_out_B(csb_out_B),
    .csb_out_C(csb_out_C), .csb_out_D(csb_out_D),
    .rd_valid(rd_valid), .wr_done(wr_done), .err(err)
  );

  wire [3:0]  csb_v = {csb_A, csb_B, csb_C, csb_D};
  wire [31:0] din_v = {din_A, din_B, din_C, din_D};
  wire [3:0]  cso_v = {csb_out_A, csb_out_B, csb_out_C, csb_out_D};
  wire [2:0]  pls_v = {rd_valid, wr_done, err};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for exactly one edge; returns in the cycle after acceptance.
  task automatic issue(input logic we, input logic [1:0] size,
                       input logic [ROW_W+1:0] addr, input logic [31:0] data);
    req_valid   = 1'b1;
    req_we      = we;
    req_size    = size;
    req_addr    = addr;
    d_fabric_in = data;
    step();
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_size    = 2'b00;
    req_addr    = '0;
    d_fabric_in = 32'h0;
  endtask

  // Illegal request: one err cycle with no bank select, then ready again.
  task automatic expect_err(input string tag, input logic [1:0] size, input logic [ROW_W+1:0] addr);
    issue(1'b0, size, addr, 32'hFFFF_FFFF);
    chk({tag, "_pulse"}, 32'(pls_v), 32'b001);
    chk({tag, "_csb"},   32'(csb_v), 32'hF);
    chk({tag, "_rdy0"},  32'(req_ready), 32'd0);
    step();
    chk({tag, "_clr"},   32'(pls_v), 32'b000);
    chk({tag, "_rdy1"},  32'(req_ready), 32'd1);
  endtask

  // Legal read: check bank access cycle and response lane flags.
  task automatic expect_rd(input string tag, input logic [1:0] size, input logic [ROW_W+1:0] addr,
                           input logic [3:0] csb_e, input logic [ROW_W-1:0] row_e, input logic [3:0] cso_e);
    issue(1'b0, size, addr, 32'h0);
    chk({tag, "_acc_csb"}, 32'(csb_v), 32'(csb_e));
    chk({tag, "_acc_web"}, 32'(web), 32'd1);
    chk({tag, "_acc_row"}, 32'(sram_addr), 32'(row_e));
    step();
    chk({tag, "_rsp_csb"}, 32'(csb_v), 32'hF);
    chk({tag, "_rsp_cso"}, 32'(cso_v), 32'(cso_e));
    chk({tag, "_rsp_pls"}, 32'(pls_v), 32'b100);
    step();
    chk({tag, "_idle_pls"}, 32'(pls_v), 32'b000);
    chk({tag, "_idle_rdy"}, 32'(req_ready), 32'd1);
  endtask

  // Legal write: check bank access cycle, data lanes and wr_done.
  task automatic expect_wr(input string tag, input logic [1:0] size, input logic [ROW_W+1:0] addr,
                           input logic [31:0] data, input logic [3:0] csb_e,
                           input logic [ROW_W-1:0] row_e, input logic [31:0] din_e);
    issue(1'b1, size, addr, data);
    chk({tag, "_acc_csb"}, 32'(csb_v), 32'(csb_e));
    chk({tag, "_acc_web"}, 32'(web), 32'd0);
    chk({tag, "_acc_row"}, 32'(sram_addr), 32'(row_e));
    chk({tag, "_acc_din"}, din_v, din_e);
    chk({tag, "_acc_rdy"}, 32'(req_ready), 32'd0);
    step();
    chk({tag, "_rsp_csb"}, 32'(csb_v), 32'hF);
    chk({tag, "_rsp_web"}, 32'(web), 32'd1);
    chk({tag, "_rsp_cso"}, 32'(cso_v), 32'h0);
    chk({tag, "_rsp_pls"}, 32'(pls_v), 32'b010);
    step();
    chk({tag, "_idle_pls"}, 32'(pls_v), 32'b000);
    chk({tag, "_idle_rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int acc_cnt;
    int rdv_cnt;
    int back2back;
    logic prev_rdv;

    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'b00;
    req_addr = '0;
    d_fabric_in = 32'h0;
    step();
    step();

    // Reset values
    chk("rst_rdy",  32'(req_ready), 32'd0);
    chk("rst_csb",  32'(csb_v), 32'hF);
    chk("rst_web",  32'(web), 32'd1);
    chk("rst_row",  32'(sram_addr), 32'd0);
    chk("rst_din",  din_v, 32'h0);
    chk("rst_cso",  32'(cso_v), 32'h0);
    chk("rst_pls",  32'(pls_v), 32'b000);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(req_ready), 32'd1);

    expect_wr("wr_word",  2'b10, 11'h010, 32'hDEAD_BEEF, 4'b0000, 9'h004, 32'hDEAD_BEEF);
    expect_rd("rd_byte3", 2'b00, 11'h013, 4'b1110, 9'h004, 4'b0001);
    expect_wr("wr_half2", 2'b01, 11'h002, 32'h0000_1234, 4'b1100, 9'h000, 32'h0000_1234);
    expect_wr("wr_half0", 2'b01, 11'h7FC, 32'hFFFF_A55A, 4'b0011, 9'h1FF, 32'hA55A_0000);
    expect_wr("wr_byte1", 2'b00, 11'h021, 32'h1234_56C3, 4'b1011, 9'h008, 32'h00C3_0000);
    expect_rd("rd_byte1", 2'b00, 11'h005, 4'b1011, 9'h001, 4'b0100);
    expect_rd("rd_half2", 2'b01, 11'h00E, 4'b1100, 9'h003, 4'b0011);
    expect_rd("rd_word",  2'b10, 11'h100, 4'b0000, 9'h040, 4'b1111);

    expect_err("err_half1", 2'b01, 11'h001);
    expect_err("err_size3", 2'b11, 11'h000);
    expect_err("err_word1", 2'b10, 11'h005);

    // req_valid held high: accepts every third cycle
    acc_cnt = 0;
    rdv_cnt = 0;
    back2back = 0;
    prev_rdv = 1'b0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 2'b00;
    req_addr = 11'h020;
    for (int i = 0; i < 9; i++) begin
      if (req_ready) acc_cnt++;
      step();
      if (rd_valid) rdv_cnt++;
      if (rd_valid && prev_rdv) back2back++;
      prev_rdv = rd_valid;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rd_valid) rdv_cnt++;
    end
    chk("b2b_accepts", 32'(acc_cnt), 32'd3);
    chk("b2b_rd_valid", 32'(rdv_cnt), 32'd3);
    chk("b2b_consec", 32'(back2back), 32'd0);

    // Reset during ACCESS of a read aborts it
    issue(1'b0, 2'b00, 11'h000, 32'h0);
    chk("abort_acc_csb", 32'(csb_v), 32'h7);
    rst = 1'b1;
    step();
    chk("abort_csb", 32'(csb_v), 32'hF);
    chk("abort_web", 32'(web), 32'd1);
    chk("abort_cso", 32'(cso_v), 32'h0);
    chk("abort_pls", 32'(pls_v), 32'b000);
    chk("abort_rdy_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_rdy_after", 32'(req_ready), 32'd1);
    step();
    chk("abort_no_rdv", 32'(pls_v), 32'b000);
    step();
    chk("abort_no_rdv2", 32'(pls_v), 32'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
